bus_arb2: RTL and testbench

Two-master arbiter that shares the single downstream memory/peripheral request port between the CPU bus interface (master 0) and a second bus master such as a DMA or debug engine (master 1). It sits between the CPU interface and the memory/peripheral interconnect. It grants one master at a time, forwards that master's request, and holds the grant for the whole transfer (1..7 beats, line bursts included). It routes write beats downstream and read beats back to the granted master only.

---
 rtl/bus_pkg.sv | 27 ++
 rtl/arb_rr2.sv | 31 +++
 rtl/bus_arb2.sv | 162 ++++++++++++++++
 tb/tb_bus_arb2.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types for the two-master bus arbiter: FSM encoding, field widths, request payload.
package bus_pkg;

    localparam int unsigned LEN_W  = 3;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_XFER = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [MASK_W-1:0] mask;
        logic [ADDR_W-1:0] addr;
        logic              we;
    } bus_req_t;

    // A zero length still moves one beat.
    function automatic logic [LEN_W-1:0] first_beat_cnt(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-input one-hot grant picker; BUS_ARB_FIXED_PRIO_EN selects fixed master-0 priority,
// otherwise rr_ptr_i names the master that wins a tie.
module arb_rr2 (
    input  logic [1:0] req_i,
    input  logic       rr_ptr_i,
    output logic [1:0] gnt_c
);

    always_comb begin
        gnt_c = 2'b00;
`ifdef BUS_ARB_FIXED_PRIO_EN
        if (req_i[0]) begin
            gnt_c = 2'b01;
        end else if (req_i[1]) begin
            gnt_c = 2'b10;
        end
`else
        if (req_i == 2'b11) begin
            gnt_c = rr_ptr_i ? 2'b10 : 2'b01;
        end else begin
            gnt_c = req_i;
        end
`endif
    end

`ifdef BUS_ARB_FIXED_PRIO_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr_i;
`endif

endmodule

// File: rtl/bus_arb2.sv
// Two-master arbiter onto one downstream request port; grant is held for the whole burst.
// Optional BUS_ARB_FIXED_PRIO_EN gives master 0 fixed priority instead of round-robin.
module bus_arb2
    import bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   m0_req_valid,
    output logic                   m0_req_ready,
    input  logic [2:0]             m0_req_len,
    input  logic [3:0]             m0_req_mask,
    input  logic [31:0]            m0_req_addr,
    input  logic                   m0_req_we,
    input  logic                   m0_write_valid,
    input  logic [31:0]            m0_write_data,
    output logic                   m0_read_valid,
    output logic [31:0]            m0_read_data,
    input  logic                   m0_read_ack,

    input  logic                   m1_req_valid,
    output logic                   m1_req_ready,
    input  logic [2:0]             m1_req_len,
    input  logic [3:0]             m1_req_mask,
    input  logic [31:0]            m1_req_addr,
    input  logic                   m1_req_we,
    input  logic                   m1_write_valid,
    input  logic [31:0]            m1_write_data,
    output logic                   m1_read_valid,
    output logic [31:0]            m1_read_data,
    input  logic                   m1_read_ack,

    output logic                   s_req_valid,
    output logic [2:0]             s_req_len,
    output logic [3:0]             s_req_mask,
    output logic [31:0]            s_req_addr,
    output logic                   s_req_we,
    input  logic                   s_req_ready,
    output logic                   s_write_valid,
    output logic [31:0]            s_write_data,
    input  logic                   s_read_valid,
    input  logic [31:0]            s_read_data,
    output logic                   s_read_ack,

    output logic [NUM_MASTERS-1:0] grant,
    output logic                   busy
);

    arb_state_e       state_q, state_d;
    bus_req_t         req_q, req_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [1:0]       grant_q, grant_d;
    logic             rr_q, rr_d;
    logic             busy_q, busy_d;

    bus_req_t   m0_req, m1_req, win_req;
    logic [1:0] win;
    logic       xfer_wr, xfer_rd;
    logic       wv_sel, ack_sel, beat;

    assign m0_req  = '{len: m0_req_len, mask: m0_req_mask, addr: m0_req_addr, we: m0_req_we};
    assign m1_req  = '{len: m1_req_len, mask: m1_req_mask, addr: m1_req_addr, we: m1_req_we};
    assign win_req = win[1] ? m1_req : m0_req;

    arb_rr2 u_pick (
        .req_i    ({m1_req_valid, m0_req_valid}),
        .rr_ptr_i (rr_q),
        .gnt_c    (win)
    );

    // Beat qualification: only the granted master's strobes count.
    assign xfer_wr = (state_q == ARB_XFER) && req_q.we;
    assign xfer_rd = (state_q == ARB_XFER) && !req_q.we;
    assign wv_sel  = (grant_q[0] & m0_write_valid) | (grant_q[1] & m1_write_valid);
    assign ack_sel = (grant_q[0] & m0_read_ack) | (grant_q[1] & m1_read_ack);
    assign beat    = (xfer_wr & wv_sel) | (xfer_rd & ack_sel);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            req_q      <= '0;
            beat_cnt_q <= '0;
            grant_q    <= 2'b00;
            rr_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        beat_cnt_d = beat_cnt_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|win) begin
                    state_d    = ARB_REQ;
                    req_d      = win_req;
                    beat_cnt_d = first_beat_cnt(win_req.len);
                    grant_d    = win;
                end
            end
            ARB_REQ: begin
                if (s_req_ready) begin
                    state_d = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (beat) begin
                    if (beat_cnt_q == LEN_W'(1)) begin
                        state_d = ARB_IDLE;
                        grant_d = 2'b00;
                        rr_d    = grant_q[0];
                    end else begin
                        beat_cnt_d = beat_cnt_q - LEN_W'(1);
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    // Output routing; everything not owned by the granted master is forced to zero.
    always_comb begin
        s_req_valid   = (state_q == ARB_REQ);
        s_req_len     = req_q.len;
        s_req_mask    = req_q.mask;
        s_req_addr    = req_q.addr;
        s_req_we      = req_q.we;
        m0_req_ready  = (state_q == ARB_REQ) && s_req_ready && grant_q[0];
        m1_req_ready  = (state_q == ARB_REQ) && s_req_ready && grant_q[1];

        s_write_valid = xfer_wr & wv_sel;
        s_write_data  = '0;
        if (xfer_wr && grant_q[0]) begin
            s_write_data = m0_write_data;
        end else if (xfer_wr && grant_q[1]) begin
            s_write_data = m1_write_data;
        end

        m0_read_valid = xfer_rd & grant_q[0] & s_read_valid;
        m1_read_valid = xfer_rd & grant_q[1] & s_read_valid;
        m0_read_data  = (xfer_rd && grant_q[0]) ? s_read_data : '0;
        m1_read_data  = (xfer_rd && grant_q[1]) ? s_read_data : '0;
        s_read_ack    = xfer_rd & ack_sel;

        grant         = grant_q;
        busy          = busy_q;
    end

endmodule

// File: tb/tb_bus_arb2.sv
// Directed self-checking bench for bus_arb2 with hand-computed expectations.
module tb_bus_arb2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_write_valid, m0_read_valid, m0_read_ack;
    logic [2:0]  m0_req_len;
    logic [3:0]  m0_req_mask;
    logic [31:0] m0_req_addr, m0_write_data, m0_read_data;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_write_valid, m1_read_valid, m1_read_ack;
    logic [2:0]  m1_req_len;
    logic [3:0]  m1_req_mask;
    logic [31:0] m1_req_addr, m1_write_data, m1_read_data;
    logic        s_req_valid, s_req_we, s_req_ready, s_write_valid, s_read_valid, s_read_ack;
    logic [2:0]  s_req_len;
    logic [3:0]  s_req_mask;
    logic [31:0] s_req_addr, s_write_data, s_read_data;
    logic [1:0]  grant;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    bus_arb2 #(.NUM_MASTERS(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_len(m0_req_len),
        .m0_req_mask(m0_req_mask), .m0_req_addr(m0_req_addr), .m0_req_we(m0_req_we),
        .m0_write_valid(m0_write_valid), .m0_write_data(m0_write_data),
        .m0_read_valid(m0_read_valid), .m0_read_data(m0_read_data), .m0_read_ack(m0_read_ack),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_len(m1_req_len),
        .m1_req_mask(m1_req_mask), .m1_req_addr(m1_req_addr), .m1_req_we(m1_req_we),
        .m1_write_valid(m1_write_valid), .m1_write_data(m1_write_data),
        .m1_read_valid(m1_read_valid), .m1_read_data(m1_read_data), .m1_read_ack(m1_read_ack),
        .s_req_valid(s_req_valid), .s_req_len(s_req_len), .s_req_mask(s_req_mask),
        .s_req_addr(s_req_addr), .s_req_we(s_req_we), .s_req_ready(s_req_ready),
        .s_write_valid(s_write_valid), .s_write_data(s_write_data),
        .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ack(s_read_ack),
        .grant(grant), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 2 time units after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic clear_inputs();
        m0_req_valid = 0; m0_req_len = 0; m0_req_mask = 0; m0_req_addr = 0; m0_req_we = 0;
        m0_write_valid = 0; m0_write_data = 0; m0_read_ack = 0;
        m1_req_valid = 0; m1_req_len = 0; m1_req_mask = 0; m1_req_addr = 0; m1_req_we = 0;
        m1_write_valid = 0; m1_write_data = 0; m1_read_ack = 0;
        s_req_ready = 0; s_read_valid = 0; s_read_data = 0;
    endtask

    logic [1:0]  exp_g2;
    logic [31:0] exp_a2;

    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        cyc(2);
        chk("rst_s_req_valid", 32'(s_req_valid), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s_req_addr", s_req_addr, 0);
        chk("rst_s_write_valid", 32'(s_write_valid), 0);
        rst_ni = 1'b1;
        cyc(1);

        // s_read_valid in IDLE does not reach either master
        s_read_valid = 1; s_read_data = 32'hCAFE0000; #1;
        chk("idle_rd_ignored", 32'(m0_read_valid), 0);
        chk("idle_rd_data0", m0_read_data, 0);
        s_read_valid = 0; s_read_data = 0;

        // Single read, len 1, from m0
        m0_req_valid = 1; m0_req_len = 3'd1; m0_req_mask = 4'hF; m0_req_addr = 32'h0000_4000; m0_req_we = 0;
        #1 chk("t1_idle_no_sreq", 32'(s_req_valid), 0);
        cyc(1);
        m0_req_valid = 0;
        chk("t1_s_req_valid", 32'(s_req_valid), 1);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_addr", s_req_addr, 32'h0000_4000);
        chk("t1_busy", 32'(busy), 1);
        s_req_ready = 1; #1;
        chk("t1_m0_req_ready", 32'(m0_req_ready), 1);
        chk("t1_m1_req_ready", 32'(m1_req_ready), 0);
        cyc(1);
        s_req_ready = 0;
        chk("t1_xfer_no_sreq", 32'(s_req_valid), 0);
        s_read_valid = 1; s_read_data = 32'hDEADBEEF; #1;
        chk("t1_m0_rv", 32'(m0_read_valid), 1);
        chk("t1_m0_rd", m0_read_data, 32'hDEADBEEF);
        chk("t1_m1_rv", 32'(m1_read_valid), 0);
        chk("t1_m1_rd", m1_read_data, 0);
        m0_read_ack = 1; #1;
        chk("t1_s_read_ack", 32'(s_read_ack), 1);
        cyc(1);
        clear_inputs(); #1;
        chk("t1_end_grant", 32'(grant), 0);
        chk("t1_end_busy", 32'(busy), 0);

        // Line write, len 4, from m1; m0 strobes must not leak through
        m1_req_valid = 1; m1_req_len = 3'd4; m1_req_mask = 4'hF; m1_req_addr = 32'h0000_1000; m1_req_we = 1;
        cyc(1);
        m1_req_valid = 0;
        chk("t2_grant", 32'(grant), 32'h2);
        chk("t2_we", 32'(s_req_we), 1);
        chk("t2_len", 32'(s_req_len), 4);
        s_req_ready = 1; #1;
        chk("t2_m1_req_ready", 32'(m1_req_ready), 1);
        chk("t2_m0_req_ready", 32'(m0_req_ready), 0);
        cyc(1);
        s_req_ready = 0;
        m0_write_valid = 1; m0_write_data = 32'h5555_5555; #1;
        chk("t2_m0_wv_blocked", 32'(s_write_valid), 0);
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            m1_write_valid = 1; m1_write_data = 32'hA000_0000 + 32'(i); #1;
            chk("t2_s_wv", 32'(s_write_valid), 1);
            chk("t2_s_wd", s_write_data, 32'hA000_0000 + 32'(i));
            chk("t2_busy_during", 32'(busy), 1);
            cyc(1);
        end
        m1_write_valid = 0; #1;
        chk("t2_busy_after", 32'(busy), 0);
        chk("t2_grant_after", 32'(grant), 0);
        chk("t2_no_extra_wv", 32'(s_write_valid), 0);
        clear_inputs();

        // Simultaneous requests, twice in a row
        m0_req_valid = 1; m0_req_len = 3'd1; m0_req_addr = 32'h100;
        m1_req_valid = 1; m1_req_len = 3'd1; m1_req_addr = 32'h200;
        cyc(1);
        chk("t3_grant1", 32'(grant), 32'h1);
        chk("t3_addr1", s_req_addr, 32'h100);
        s_req_ready = 1; cyc(1); s_req_ready = 0;
        s_read_valid = 1; m0_read_ack = 1; m1_read_ack = 1;
        cyc(1);
        s_read_valid = 0; m0_read_ack = 0; m1_read_ack = 0;
        cyc(1);
`ifdef BUS_ARB_FIXED_PRIO_EN
        exp_g2 = 2'b01; exp_a2 = 32'h100;
`else
        exp_g2 = 2'b10; exp_a2 = 32'h200;
`endif
        chk("t3_grant2", 32'(grant), 32'(exp_g2));
        chk("t3_addr2", s_req_addr, exp_a2);
        m0_req_valid = 0; m1_req_valid = 0;
        s_req_ready = 1; cyc(1); s_req_ready = 0;
        s_read_valid = 1; m0_read_ack = 1; m1_read_ack = 1;
        cyc(1);
        clear_inputs(); #1;
        chk("t3_idle", 32'(busy), 0);

        // s_req_ready held low for 5 cycles in REQ
        m0_req_valid = 1; m0_req_len = 3'd2; m0_req_mask = 4'b0011; m0_req_addr = 32'h3000; m0_req_we = 1;
        cyc(1);
        m0_req_valid = 0; m0_req_addr = 32'hFFFF_FFFF; m0_req_mask = 4'hF;
        for (int i = 0; i < 5; i++) begin
            chk("t4_sreq_hold", 32'(s_req_valid), 1);
            chk("t4_addr_stable", s_req_addr, 32'h3000);
            chk("t4_mask_stable", 32'(s_req_mask), 32'h3);
            chk("t4_no_ready", 32'(m0_req_ready), 0);
            cyc(1);
        end
        s_req_ready = 1; #1;
        chk("t4_ready_pulse", 32'(m0_req_ready), 1);
        cyc(1);
        chk("t4_ready_once", 32'(m0_req_ready), 0);
        s_req_ready = 0;
        m0_write_valid = 1; m0_write_data = 32'h11; cyc(1);
        chk("t4_busy_mid", 32'(busy), 1);
        m0_write_data = 32'h22; cyc(1);
        clear_inputs(); #1;
        chk("t4_done", 32'(busy), 0);

        // Reset asserted mid-read after beat 2 of 4
        m0_req_valid = 1; m0_req_len = 3'd4; m0_req_addr = 32'h6000; m0_req_we = 0;
        cyc(1);
        m0_req_valid = 0; s_req_ready = 1; cyc(1); s_req_ready = 0;
        s_read_valid = 1; s_read_data = 32'h0BEE_0001; m0_read_ack = 1;
        cyc(2);
        #1 rst_ni = 1'b0; #1;
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_grant", 32'(grant), 0);
        chk("t5_rst_rv", 32'(m0_read_valid), 0);
        chk("t5_rst_rd", m0_read_data, 0);
        chk("t5_rst_ack", 32'(s_read_ack), 0);
        chk("t5_rst_addr", s_req_addr, 0);
        clear_inputs();
        cyc(1);
        rst_ni = 1'b1;

        // New m1 request after reset, len 0 write = one beat
        m1_req_valid = 1; m1_req_len = 3'd0; m1_req_addr = 32'h7000; m1_req_we = 1;
        cyc(1);
        m1_req_valid = 0;
        chk("t6_grant", 32'(grant), 32'h2);
        chk("t6_addr", s_req_addr, 32'h7000);
        s_req_ready = 1; #1;
        chk("t6_m1_ready", 32'(m1_req_ready), 1);
        cyc(1);
        s_req_ready = 0;
        m1_write_valid = 1; m1_write_data = 32'h1234_5678; #1;
        chk("t6_wv", 32'(s_write_valid), 1);
        chk("t6_wd", s_write_data, 32'h1234_5678);
        cyc(1);
        chk("t6_idle_busy", 32'(busy), 0);
        chk("t6_idle_grant", 32'(grant), 0);
        chk("t6_wv_outside", 32'(s_write_valid), 0);
        clear_inputs();
        cyc(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
